// File: rtl/uart_dec_rx.sv
// uart_dec_rx: UART 8N1 receiver followed by an ASCII decimal line parser.
//
// Bytes are deserialised from uartx_i (LSB first, one start bit, one stop bit).
// Decimal digits are accumulated. A CR (0x0D) or LF (0x0A) terminates the line
// and either publishes the value or reports a rejected line.
//
// Optional feature macro: UART_DEC_OVF_EN
//   defined   : a 6th digit, or any digit that would take the value above 65535,
//               marks the line bad (parse_err at the terminator, no value).
//   undefined : the accumulator wraps modulo 2^16 after every digit.
//
// Ports:
//   clk_i            system clock (single domain)
//   rst_i            asynchronous active-high reset
//   uartx_i          serial line, idle high, asynchronous to clk_i
//   rx_byte_o        last correctly framed data byte
//   rx_byte_valid_o  one-cycle pulse, rx_byte_o valid in the same cycle
//   value_o          last accepted decimal value, held until the next accepted line
//   value_valid_o    one-cycle pulse when value_o updates
//   frame_err_o      one-cycle pulse when the stop bit is sampled low
//   parse_err_o      one-cycle pulse when a terminated line is rejected

module uart_dec_rx #(
    parameter int unsigned CLK_HZ = 12000000,
    parameter int unsigned BAUD   = 9600
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        uartx_i,
    output logic [7:0]  rx_byte_o,
    output logic        rx_byte_valid_o,
    output logic [15:0] value_o,
    output logic        value_valid_o,
    output logic        frame_err_o,
    output logic        parse_err_o
);

    localparam int unsigned DIV  = CLK_HZ / BAUD;
    localparam int unsigned HALF = DIV / 2;
    localparam int unsigned CW   = (DIV > 2) ? $clog2(DIV) : 1;

    localparam logic [CW-1:0] DivLast  = CW'(DIV - 1);
    localparam logic [CW-1:0] HalfLast = CW'(HALF - 1);

    typedef enum logic [1:0] {StIdle, StStart, StData, StStop} state_e;

    // ------------------------------------------------------------------
    // Input synchroniser
    // ------------------------------------------------------------------
    logic [1:0] sync_q;
    logic       rxs;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            sync_q <= 2'b11;
        end else begin
            sync_q <= {sync_q[0], uartx_i};
        end
    end

    assign rxs = sync_q[1];

    // ------------------------------------------------------------------
    // Bit-level receiver FSM
    // ------------------------------------------------------------------
    state_e        state_q;
    logic [CW-1:0] cnt_q;
    logic [2:0]    idx_q;
    logic [7:0]    shift_q;
    logic [7:0]    rx_byte_q;
    logic          rx_byte_valid_q;
    logic          frame_err_q;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q         <= StIdle;
            cnt_q           <= '0;
            idx_q           <= 3'd0;
            shift_q         <= 8'h00;
            rx_byte_q       <= 8'h00;
            rx_byte_valid_q <= 1'b0;
            frame_err_q     <= 1'b0;
        end else begin
            rx_byte_valid_q <= 1'b0;
            frame_err_q     <= 1'b0;
            unique case (state_q)
                StIdle: begin
                    if (!rxs) begin
                        cnt_q   <= '0;
                        state_q <= StStart;
                    end
                end
                StStart: begin
                    // Mid-start-bit check rejects short glitches.
                    if (cnt_q == HalfLast) begin
                        if (!rxs) begin
                            cnt_q   <= '0;
                            idx_q   <= 3'd0;
                            state_q <= StData;
                        end else begin
                            state_q <= StIdle;
                        end
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                StData: begin
                    if (cnt_q == DivLast) begin
                        cnt_q          <= '0;
                        shift_q[idx_q] <= rxs;
                        if (idx_q == 3'd7) begin
                            state_q <= StStop;
                        end else begin
                            idx_q <= idx_q + 3'd1;
                        end
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                StStop: begin
                    // Return to idle at mid-stop so an early next start bit is caught.
                    if (cnt_q == DivLast) begin
                        cnt_q <= '0;
                        if (rxs) begin
                            rx_byte_q       <= shift_q;
                            rx_byte_valid_q <= 1'b1;
                        end else begin
                            frame_err_q <= 1'b1;
                        end
                        state_q <= StIdle;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Decimal line parser
    // ------------------------------------------------------------------
    logic [16:0] acc_q;
    logic [2:0]  ndig_q;
    logic        bad_q;
    logic [15:0] value_q;
    logic        value_valid_q;
    logic        parse_err_q;

    logic        is_digit;
    logic        is_term;
    logic [20:0] prod;
    logic [16:0] acc_d;
    logic [2:0]  ndig_inc;
    logic        dig_ovf;

    always_comb begin
        is_digit = (rx_byte_q >= 8'h30) && (rx_byte_q <= 8'h39);
        is_term  = (rx_byte_q == 8'h0D) || (rx_byte_q == 8'h0A);
        // For '0'..'9' the digit value is simply the low nibble.
        prod     = 21'(acc_q) * 21'd10 + 21'(rx_byte_q[3:0]);
        ndig_inc = (ndig_q == 3'd7) ? 3'd7 : ndig_q + 3'd1;
`ifdef UART_DEC_OVF_EN
        dig_ovf  = (ndig_q >= 3'd5) || (prod > 21'd65535);
        acc_d    = prod[16:0];
`else
        dig_ovf  = 1'b0;
        acc_d    = 17'(prod % 21'd65536);
`endif
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            acc_q         <= 17'd0;
            ndig_q        <= 3'd0;
            bad_q         <= 1'b0;
            value_q       <= 16'd0;
            value_valid_q <= 1'b0;
            parse_err_q   <= 1'b0;
        end else begin
            value_valid_q <= 1'b0;
            parse_err_q   <= 1'b0;
            if (frame_err_q) begin
                bad_q <= 1'b1;
            end else if (rx_byte_valid_q) begin
                if (is_digit) begin
                    acc_q  <= acc_d;
                    ndig_q <= ndig_inc;
                    if (dig_ovf) begin
                        bad_q <= 1'b1;
                    end
                end else if (is_term) begin
                    // Empty clean lines are dropped so CR LF yields one value.
                    if (bad_q) begin
                        parse_err_q <= 1'b1;
                    end else if (ndig_q != 3'd0) begin
                        value_q       <= acc_q[15:0];
                        value_valid_q <= 1'b1;
                    end
                    acc_q  <= 17'd0;
                    ndig_q <= 3'd0;
                    bad_q  <= 1'b0;
                end else begin
                    bad_q <= 1'b1;
                end
            end
        end
    end

    assign rx_byte_o       = rx_byte_q;
    assign rx_byte_valid_o = rx_byte_valid_q;
    assign frame_err_o     = frame_err_q;
    assign value_o         = value_q;
    assign value_valid_o   = value_valid_q;
    assign parse_err_o     = parse_err_q;

endmodule

// File: tb/tb_uart_dec_rx.sv
// Testbench for uart_dec_rx: directed lines with literal expectations plus random
// lines checked against a behavioural line-parser model. A fast baud rate keeps
// the run short; all timing is expressed in DIV/HALF.

module tb_uart_dec_rx;

    localparam int unsigned CLK_HZ = 12000000;
    localparam int unsigned BAUD   = 375000;
    localparam int unsigned DIV    = CLK_HZ / BAUD;
    localparam int unsigned HALF   = DIV / 2;
    // Driven start edge to visible rx pulse: 2 sync stages, idle detect, half bit, 9 bits.
    localparam int unsigned LAT    = 3 + HALF + 9 * DIV;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        uartx = 1'b1;
    logic [7:0]  rx_byte;
    logic        rbv;
    logic [15:0] value;
    logic        vv;
    logic        fe;
    logic        pe;

    uart_dec_rx #(
        .CLK_HZ (CLK_HZ),
        .BAUD   (BAUD)
    ) dut (
        .clk_i           (clk),
        .rst_i           (rst),
        .uartx_i         (uartx),
        .rx_byte_o       (rx_byte),
        .rx_byte_valid_o (rbv),
        .value_o         (value),
        .value_valid_o   (vv),
        .frame_err_o     (fe),
        .parse_err_o     (pe)
    );

    always #5 clk = ~clk;

    int unsigned cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int errors = 0;
    int checks = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Expected frame events, in order. outcome: 0 none, 1 value, 2 parse error.
    typedef struct {
        bit          is_byte;
        logic [7:0]  data;
        int unsigned due;
        int          outcome;
        logic [15:0] oval;
    } exp_t;

    exp_t expq[$];

    // Line model state.
    int  m_acc  = 0;
    int  m_ndig = 0;
    bit  m_bad  = 0;

    task automatic model_feed(input logic [7:0] b, input bit ferr,
                              output int o, output logic [15:0] v);
        int d;
        o = 0;
        v = 16'd0;
        if (ferr) begin
            m_bad = 1;
        end else if (b >= 8'h30 && b <= 8'h39) begin
            d = int'(b) - 48;
`ifdef UART_DEC_OVF_EN
            if (m_ndig >= 5 || m_acc * 10 + d > 65535) m_bad = 1;
            else m_acc = m_acc * 10 + d;
`else
            m_acc = (m_acc * 10 + d) % 65536;
`endif
            m_ndig++;
        end else if (b == 8'h0D || b == 8'h0A) begin
            if (m_bad) o = 2;
            else if (m_ndig > 0) begin
                o = 1;
                v = m_acc[15:0];
            end
            m_acc  = 0;
            m_ndig = 0;
            m_bad  = 0;
        end else begin
            m_bad = 1;
        end
    endtask

    // Monitor / compare process.
    logic [15:0] m_value  = 16'd0;
    int          pend_kind = 0;
    logic [15:0] pend_val  = 16'd0;
    int unsigned pend_cyc  = 0;
    int n_rbv = 0, n_vv = 0, n_pe = 0, n_fe = 0;

    always @(negedge clk) begin
        exp_t e;
        bit   exp_vv;
        bit   exp_pe;
        if (rst) begin
            check("reset_outputs", {4'd0, rx_byte, rbv, value, vv, fe, pe}, 32'd0);
            m_value   = 16'd0;
            pend_kind = 0;
        end else begin
            n_rbv += int'(rbv);
            n_vv  += int'(vv);
            n_pe  += int'(pe);
            n_fe  += int'(fe);
            if (rbv || fe) begin
                if (expq.size() == 0) begin
                    check("unexpected_rx_event", {30'd0, rbv, fe}, 32'd0);
                end else begin
                    e = expq.pop_front();
                    check("rx_kind", {30'd0, rbv, fe}, {30'd0, e.is_byte, !e.is_byte});
                    check("rx_timing", 32'(cyc + 2 >= e.due && cyc <= e.due + 2), 32'd1);
                    if (rbv && e.is_byte) check("rx_byte", rx_byte, e.data);
                    pend_kind = e.outcome;
                    pend_val  = e.oval;
                    pend_cyc  = cyc + 1;
                end
            end else if (expq.size() > 0 && cyc > expq[0].due + 2) begin
                check("rx_missing", {31'd0, rbv | fe}, 32'd1);
                void'(expq.pop_front());
            end
            exp_vv = (pend_kind == 1) && (pend_cyc == cyc);
            exp_pe = (pend_kind == 2) && (pend_cyc == cyc);
            check("value_valid", vv, exp_vv);
            check("parse_err", pe, exp_pe);
            if (exp_vv) m_value = pend_val;
            check("value", value, m_value);
        end
    end

    // Drive one frame; abort_bit >= 0 asserts reset in the middle of that data bit.
    task automatic send_frame(input logic [7:0] b, input bit stop_ok, input int gap,
                              input int abort_bit);
        exp_t        e;
        int          o;
        logic [15:0] v;
        @(posedge clk);
        #1;
        if (abort_bit < 0) begin
            model_feed(b, !stop_ok, o, v);
            e.is_byte = stop_ok;
            e.data    = b;
            e.due     = cyc + LAT;
            e.outcome = o;
            e.oval    = v;
            expq.push_back(e);
        end
        uartx = 1'b0;
        repeat (DIV) @(posedge clk);
        #1;
        for (int i = 0; i < 8; i++) begin
            uartx = b[i];
            if (abort_bit == i) begin
                repeat (HALF) @(posedge clk);
                #1;
                rst   = 1'b1;
                uartx = 1'b1;
                expq.delete();
                m_acc  = 0;
                m_ndig = 0;
                m_bad  = 0;
                repeat (6) @(posedge clk);
                #1;
                rst = 1'b0;
                repeat (DIV) @(posedge clk);
                return;
            end
            repeat (DIV) @(posedge clk);
            #1;
        end
        uartx = stop_ok;
        repeat (DIV) @(posedge clk);
        #1;
        uartx = 1'b1;
        repeat (gap) @(posedge clk);
    endtask

    task automatic send_str(input string s);
        for (int i = 0; i < s.len(); i++) begin
            send_frame(s[i], 1'b1, int'($urandom_range(0, DIV)), -1);
        end
        repeat (4) @(posedge clk);
    endtask

    int s_rbv, s_vv, s_pe, s_fe;

    task automatic snap();
        s_rbv = n_rbv;
        s_vv  = n_vv;
        s_pe  = n_pe;
        s_fe  = n_fe;
    endtask

    task automatic check_deltas(input string name, input int drbv, input int dvv,
                                input int dpe, input int dfe);
        check({name, "_rbv"}, 32'(n_rbv - s_rbv), 32'(drbv));
        check({name, "_vv"}, 32'(n_vv - s_vv), 32'(dvv));
        check({name, "_pe"}, 32'(n_pe - s_pe), 32'(dpe));
        check({name, "_fe"}, 32'(n_fe - s_fe), 32'(dfe));
    endtask

    initial begin
        logic [7:0] ch;
        int         len;
        repeat (4) @(posedge clk);
        #1;
        rst = 1'b0;
        repeat (4) @(posedge clk);

        snap();
        send_str("00042\r\n");
        check_deltas("line42", 7, 1, 0, 0);
        check("value_42", value, 32'd42);

        snap();
        send_str("65535\r");
        check("value_65535", value, 32'd65535);
        send_str("0\n");
        check("value_0", value, 32'd0);
        check_deltas("max_then_zero", 8, 2, 0, 0);

        snap();
        send_str("70000\r");
`ifdef UART_DEC_OVF_EN
        check_deltas("oversize", 6, 0, 1, 0);
        check("value_kept", value, 32'd0);
`else
        check_deltas("oversize", 6, 1, 0, 0);
        check("value_wrapped", value, 32'd4464);
`endif

        snap();
        send_str("1a2\r");
        check_deltas("bad_char", 4, 0, 1, 0);
        send_str("9\r");
        check("value_9", value, 32'd9);

        snap();
        send_frame(8'h35, 1'b0, DIV, -1);
        send_str("\r");
        check_deltas("frame_err", 1, 0, 1, 1);

        // Short low glitch must be rejected at the mid-start check.
        snap();
        @(posedge clk);
        #1;
        uartx = 1'b0;
        repeat (HALF - 6) @(posedge clk);
        #1;
        uartx = 1'b1;
        repeat (3 * DIV) @(posedge clk);
        check_deltas("glitch", 0, 0, 0, 0);

        // Reset in the middle of data bit 4 of '3'.
        send_str("12");
        send_frame(8'h33, 1'b1, 0, 4);
        check("value_after_rst", value, 32'd0);
        snap();
        send_str("8\r");
        check_deltas("post_reset", 2, 1, 0, 0);
        check("value_8", value, 32'd8);

        // Random lines against the model.
        for (int l = 0; l < 20; l++) begin
            len = int'($urandom_range(0, 7));
            for (int k = 0; k < len; k++) begin
                if ($urandom_range(0, 9) < 8) ch = 8'(8'h30 + $urandom_range(0, 9));
                else ch = 8'($urandom_range(0, 255));
                send_frame(ch, ($urandom_range(0, 19) != 0), int'($urandom_range(0, DIV)), -1);
            end
            send_frame(($urandom_range(0, 1) != 0) ? 8'h0D : 8'h0A, 1'b1,
                       int'($urandom_range(0, DIV)), -1);
            if ($urandom_range(0, 2) == 0) send_frame(8'h0A, 1'b1, 0, -1);
        end

        for (int w = 0; w < 4 * int'(DIV) && expq.size() > 0; w++) @(posedge clk);
        repeat (4) @(posedge clk);
        check("drain", 32'(expq.size()), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
